seg7_mux_driver: RTL
====================

SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter PRESCALE, default 50000: clk cycles each digit is shown, legal range >= 2.
REQ-003 Parameter HEX_MODE, default 0: 1 decodes codes 10..15 as A,b,C,d,E,F; 0 blanks codes 10..15.
REQ-004 Parameter AN_ACTIVE_LOW, default 1: 1 means the selected anode is driven 0; 0 means it is driven 1.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 enable  input  1  1 = scanning runs; 0 = display dark and scan frozen.
REQ-008 load  input  1  1-cycle strobe that captures value and dp_in.
REQ-009 value  input  4*NUM_DIGITS  packed codes; digit k is value[4k+3:4k]; digit 0 is least significant.
REQ-010 dp_in  input  NUM_DIGITS  decimal point request per digit; 1 = lit.
REQ-011 lz_blank  input  1  1 = suppress leading zeros.
REQ-012 seg  output  [0:6]  segments a..g, registered, active-low (0 = lit).
REQ-013 dp  output  1  decimal point, registered, active-low.
REQ-014 an  output  NUM_DIGITS  one-hot anode select, registered, polarity per AN_ACTIVE_LOW.
REQ-015 frame_done  output  1  1-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Function
REQ-016 Prescaler counts 0..PRESCALE-1 while enable=1; tick asserts on the cycle where count = PRESCALE-1; count then returns to 0.
REQ-017 Digit index increments on tick; from NUM_DIGITS-1 it wraps to 0, and frame_done asserts on the same cycle as that wrapping tick.
REQ-018 Double buffering: load writes value/dp_in into a pending register and sets pending_valid.
REQ-019 The active register updates only on the wrapping tick, and only if pending_valid=1 or load=1 in that cycle; pending_valid clears at that point.
REQ-020 Load coincident with the wrapping tick: the incoming value/dp_in goes straight to the active register; no one-frame lag.
REQ-021 Back-to-back loads before a frame boundary: last write wins.
REQ-022 Decode table, seg[0:6] = a..g: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100.
REQ-023 Decode table continued: 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-024 Decode table, HEX_MODE=1 only: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-025 Blank pattern is seg=1111111; it applies to codes 10..15 when HEX_MODE=0.
REQ-026 Leading-zero suppression (lz_blank=1): digits from NUM_DIGITS-1 downward whose active code is 0 are blanked until the first non-zero digit.
REQ-027 Digit 0 is never blanked by leading-zero suppression.
REQ-028 A blanked digit still drives dp from its dp_in bit.
REQ-029 Outputs are registered: seg, dp and an reflect the current digit index and active register with 1-cycle latency.
REQ-030 an is exactly one-hot, selecting the current digit, whenever enable=1 and not in reset.
REQ-031 enable=0: prescaler and index hold; an drives all digits inactive; seg=1111111; dp=1; frame_done=0.
REQ-032 enable=0 does not block loads; the pending register still captures.
REQ-033 When enable returns to 1, scanning resumes from the held index and prescaler count.
REQ-034 Pending-to-active transfer happens only on a wrapping tick, so it stalls while enable=0.

Reset
REQ-035 rst=1 takes precedence over all other inputs, including load and enable.
REQ-036 On the cycle after rst=1 is sampled: prescaler=0, index=0, active and pending registers=0, pending_valid=0.
REQ-037 On the same cycle: seg=1111111, dp=1, an all inactive, frame_done=0.
REQ-038 Reset asserted mid-frame discards any pending load.
REQ-039 After rst deasserts with enable=1, digit 0 is selected first, and the first tick occurs PRESCALE cycles later.

Verification (all with NUM_DIGITS=4, PRESCALE=4)
REQ-040 Reset, enable=1, no load -> an cycles 1110,1101,1011,0111 every 4 clk; seg=0000001 on each digit; frame_done pulses every 16 clk.
REQ-041 load value=16'h1234 mid-frame -> displayed codes unchanged until the next wrap; from the next frame digit0=4 (1001100) and digit3=1 (1001111).
REQ-042 value=16'h0050, lz_blank=1 -> digits 3 and 2 show 1111111; digit1=5 (0100100); digit0=0 (0000001).
REQ-043 value=16'h00AF: HEX_MODE=0 -> digits 1 and 0 show 1111111; HEX_MODE=1 -> digit1=A (0001000), digit0=F (0111000).
REQ-044 enable=0 for 10 clk mid-digit -> an=1111 and seg=1111111; on re-enable the same digit resumes with its remaining count; loads during the pause take effect at the first wrap after resume.
REQ-045 load coincident with the wrapping tick, plus rst mid-frame with pending_valid=1 -> the new value appears from digit 0 of the next frame; the pending load is discarded and the outputs match REQ-036 and REQ-037.

Source files
------------

// File: rtl/seg7_mux_driver_if.sv
// rtl/seg7_mux_driver_if.sv - control, data and display signals of the seven-segment scanner
interface seg7_mux_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_blank;
    logic [0:6]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output enable, load, value, dp_in, lz_blank,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  enable, load, value, dp_in, lz_blank,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg7_mux_driver.sv
// rtl/seg7_mux_driver.sv - multiplexed seven-segment driver with double-buffered digit codes
module seg7_mux_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE      = 50000,
    parameter int HEX_MODE      = 0,
    parameter int AN_ACTIVE_LOW = 1
) (
    input logic              clk,
    input logic              rst,
    seg7_mux_driver_if.slave bus
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_valid;
    logic [4*NUM_DIGITS-1:0] act_value;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [3:0]              codes [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [0:6]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_q;

    function automatic logic [0:6] decode(input logic [3:0] c);
        logic [0:6] s;
        case (c)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        if (c > 4'd9 && HEX_MODE == 0) s = SEG_BLANK;
        return s;
    endfunction

    always_comb begin
        tick = bus.enable && (cnt == CNT_LAST);
        wrap = tick && (idx == IDX_LAST);
    end

    // A digit is a leading zero while every digit above it (and itself) is zero.
    always_comb begin
        logic lead;
        lead = 1'b1;
        lz_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            codes[k]   = act_value[4*k +: 4];
            lz_mask[k] = bus.lz_blank && lead && (codes[k] == 4'd0) && (k != 0);
            lead       = lead && (codes[k] == 4'd0);
        end
    end

    always_comb begin
        an_sel = '0;
        an_sel[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            act_value  <= '0;
            act_dp     <= '0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            an_q       <= AN_OFF;
        end else begin
            if (bus.enable) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (tick) idx <= wrap ? '0 : idx + 1'b1;

            if (bus.load) begin
                pend_value <= bus.value;
                pend_dp    <= bus.dp_in;
                pend_valid <= 1'b1;
            end

            // A load landing on the wrap bypasses the pending buffer.
            if (wrap) begin
                if (bus.load) begin
                    act_value <= bus.value;
                    act_dp    <= bus.dp_in;
                end else if (pend_valid) begin
                    act_value <= pend_value;
                    act_dp    <= pend_dp;
                end
                pend_valid <= 1'b0;
            end

            if (bus.enable) begin
                seg_q <= lz_mask[idx] ? SEG_BLANK : decode(codes[idx]);
                dp_q  <= ~act_dp[idx];
                an_q  <= (AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel;
            end else begin
                seg_q <= SEG_BLANK;
                dp_q  <= 1'b1;
                an_q  <= AN_OFF;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = wrap;
endmodule
